// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the FP multiplier issue/collect shell.
//   FP_W        : IEEE-754 single-precision word width
//   MUL_LATENCY : cycles from operand presentation to result on mul_* outputs
//   fp_flags_t  : multiplier status {exception, overflow, underflow} as bits [2:0]
//   fp_result_t : a result word together with its status flags
package fp_mult_pkg;

  localparam int FP_W        = 32;
  localparam int MUL_LATENCY = 4;

  typedef struct packed {
    logic exception;
    logic overflow;
    logic underflow;
  } fp_flags_t;

  typedef struct packed {
    logic [FP_W-1:0] result;
    fp_flags_t       flags;
  } fp_result_t;

endpackage

// File: rtl/fp_mult_issue_collect_if.sv
// Operand-issue and result-collect handshake bundle.
//   in_valid/in_ready/in_a/in_b/in_tag          : operand pair channel
//   out_valid/out_ready/out_result/out_tag/out_flags : result channel
//
// Both channels use strict valid/ready semantics: a beat transfers on a
// rising clk edge where valid and ready are both high; the producer keeps
// valid and its payload stable until that beat transfers, and valid never
// depends combinationally on ready.
// The master modport is the producer of operands / consumer of results;
// the slave modport is the shell itself.
interface fp_mult_issue_collect_if #(
  parameter int TAG_W = 4
);
  import fp_mult_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [FP_W-1:0]  in_a;
  logic [FP_W-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [FP_W-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  fp_flags_t        out_flags;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_flags
  );

endinterface

// File: rtl/fp_result_fifo.sv
// Generic synchronous FIFO with a registered head.
//   clk, reset  : clock, synchronous active-high reset
//   push        : write push_data this cycle
//   pop         : consume the head this cycle (ignored when empty)
//   out_valid   : FIFO holds at least one entry
//   out_data    : head entry, held in a register (no fall-through)
//   count       : number of stored entries, 0..DEPTH
// Push and pop together are legal at any occupancy including full.
module fp_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_next;
  logic             pop_eff;
  logic [AW:0]      count_after_pop;
  logic [AW:0]      count_next;
  logic [WIDTH-1:0] head_next;

  always_comb begin
    pop_eff         = pop && (count != '0);
    count_after_pop = count - (AW+1)'(pop_eff);
    count_next      = count_after_pop + (AW+1)'(push);
    rd_ptr_next     = rd_ptr + AW'(pop_eff);
    // When the FIFO is (or becomes) empty apart from this cycle's write, the
    // new head is the entry being written, which is not yet in mem.
    head_next = (push && (count_after_pop == '0)) ? push_data : mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_data <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      if (count_next != '0) out_data <= head_next;
    end
  end

  assign out_valid = (count != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop_eff && (count == FULL_CNT)));

endmodule

// File: rtl/fp_mult_issue_collect.sv
// Valid/ready shell around the fixed-latency, non-stalling FP multiplier.
//   clk, reset     : clock, synchronous active-high reset (shared with multiplier)
//   bus            : operand-issue / result-collect handshake (slave side)
//   mul_a, mul_b   : operands to the multiplier, zero when nothing issues
//   mul_result     : multiplier result, LATENCY cycles after mul_a/mul_b
//   mul_flags      : multiplier {exception, overflow, underflow}
//   sticky_flags   : OR of all pushed flags since reset or last clear
//   clear_sticky   : clear sticky_flags (a same-cycle push still lands)
//   occupancy      : result FIFO entry count
// A credit counter reserves a FIFO slot at issue time, so the pipe can never
// deliver a result the FIFO has no room for, even with out_ready held low.
module fp_mult_issue_collect
  import fp_mult_pkg::*;
#(
  parameter int LATENCY = MUL_LATENCY,
  parameter int DEPTH   = 8,
  parameter int TAG_W   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  fp_mult_issue_collect_if.slave      bus,
  output logic [FP_W-1:0]             mul_a,
  output logic [FP_W-1:0]             mul_b,
  input  logic [FP_W-1:0]             mul_result,
  input  fp_flags_t                   mul_flags,
  output fp_flags_t                   sticky_flags,
  input  logic                        clear_sticky,
  output logic [$clog2(DEPTH):0]      occupancy
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    fp_result_t       res;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic             issue;
  logic             pop;
  logic             push;
  logic [CW-1:0]    credits;
  logic [LATENCY-1:0] vld;
  logic [TAG_W-1:0] tag_pipe [LATENCY];
  entry_t           push_entry;
  entry_t           head;

  // in_ready comes from the registered credit count only.
  assign bus.in_ready = (credits != '0);
  assign issue        = bus.in_valid & bus.in_ready;
  assign pop          = bus.out_valid & bus.out_ready;
  assign push         = vld[LATENCY-1];

  assign mul_a = issue ? bus.in_a : '0;
  assign mul_b = issue ? bus.in_b : '0;

  // Credits: free FIFO slots not yet claimed by an in-flight or stored result.
  always_ff @(posedge clk) begin
    if (reset) credits <= CW'(DEPTH);
    else       credits <= credits - CW'(issue) + CW'(pop);
  end

  // Valid/tag pipe runs alongside the multiplier; the last stage lines up
  // with the cycle in which mul_result/mul_flags belong to that op.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      vld         <= {vld[LATENCY-2:0], issue};
      tag_pipe[0] <= bus.in_tag;
      for (int i = 1; i < LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_comb begin
    push_entry            = '0;
    push_entry.res.result = mul_result;
    push_entry.res.flags  = mul_flags;
    push_entry.tag        = tag_pipe[LATENCY-1];
  end

  fp_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .out_valid (bus.out_valid),
    .out_data  (head),
    .count     (occupancy)
  );

  assign bus.out_result = head.res.result;
  assign bus.out_tag    = head.tag;
  assign bus.out_flags  = head.res.flags;

  always_ff @(posedge clk) begin
    if (reset) sticky_flags <= '0;
    else       sticky_flags <= (clear_sticky ? fp_flags_t'(3'b000) : sticky_flags)
                             | (push ? mul_flags : fp_flags_t'(3'b000));
  end

endmodule

// File: tb/tb_fp_mult_issue_collect.sv
// Self-checking bench for fp_mult_issue_collect with a behavioural stand-in
// for the 4-cycle FP multiplier and an expected-result queue.
module tb_fp_mult_issue_collect;
  import fp_mult_pkg::*;

  localparam int DEPTH = 8;
  localparam int TAG_W = 4;
  localparam int LAT   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fp_mult_issue_collect_if #(.TAG_W(TAG_W)) bus ();
  logic [31:0] mul_a, mul_b, mul_result;
  logic [2:0]  mul_flags;
  logic [2:0]  sticky_flags;
  logic        clear_sticky;
  logic [3:0]  occupancy;

  fp_mult_issue_collect #(.LATENCY(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_result   (mul_result),
    .mul_flags    (mul_flags),
    .sticky_flags (sticky_flags),
    .clear_sticky (clear_sticky),
    .occupancy    (occupancy)
  );

  // Behavioural single-precision multiply: truncating, denormals flushed,
  // any Inf/NaN operand gives 0 with the exception flag.
  function automatic logic [34:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, e;
    logic [47:0] p;
    logic [22:0] f;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) return {32'h0, 3'b100};
    if (ea == 0 || eb == 0) return {s, 31'h0, 3'b000};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = ea + eb - 127;
    if (p[47]) begin f = p[46:24]; e = e + 1; end
    else       f = p[45:23];
    if (e > 254) return {s, 8'hFF, 23'h0, 3'b010};
    if (e < 1)   return {s, 31'h0, 3'b001};
    return {s, 8'(e), f, 3'b000};
  endfunction

  // Multiplier stand-in: fixed latency, no stall, shares reset.
  logic [34:0] mpipe [LAT];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) mpipe[i] <= '0;
    end else begin
      mpipe[0] <= fmul(mul_a, mul_b);
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_result = mpipe[LAT-1][34:3];
  assign mul_flags  = mpipe[LAT-1][2:0];

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [38:0] exp_q[$];      // {result, tag, flags} in issue order
  logic        last_iss, last_pop, last_ir, last_ov;
  logic [31:0] pop_res;
  logic [3:0]  pop_tag;
  logic [2:0]  pop_flg;
  logic [2:0]  sticky_acc;
  logic [31:0] cur_a, cur_b;
  logic [3:0]  cur_t;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp_v);
    end
  endtask

  task automatic new_op();
    cur_a = $urandom();
    cur_b = $urandom();
    cur_t = 4'($urandom_range(0, 15));
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] t, input logic ordy, input logic clr);
    logic [34:0] r;
    logic [38:0] e;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = t;
    bus.out_ready = ordy;
    clear_sticky  = clr;
    @(negedge clk);
    last_ir  = bus.in_ready;
    last_ov  = bus.out_valid;
    last_iss = v & bus.in_ready;
    last_pop = bus.out_valid & ordy;
    chk("mul_operand_gate", {mul_a, mul_b}, last_iss ? {a, b} : 64'h0);
    if (!reset && last_iss) begin
      r = fmul(a, b);
      exp_q.push_back({r[34:3], t, r[2:0]});
    end
    if (!reset && last_pop) begin
      chk("pop_expected", 64'(exp_q.size() > 0), 64'h1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pop_data", {bus.out_result, bus.out_tag, bus.out_flags}, e);
        sticky_acc = sticky_acc | e[2:0];
      end
      pop_res = bus.out_result;
      pop_tag = bus.out_tag;
      pop_flg = bus.out_flags;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 4'h0, ordy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int nt, pops, budget;
    logic seen_pop, check_ir;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0;
    bus.out_ready = 1'b0; clear_sticky = 1'b0;
    sticky_acc = '0;
    pop_res = 'x; pop_tag = 'x; pop_flg = 'x;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_occupancy", 64'(occupancy), 64'h0);
    chk("rst_sticky", 64'(sticky_flags), 64'h0);
    chk("rst_head", {bus.out_result, bus.out_tag, bus.out_flags}, 64'h0);

    // Single op, latency LAT+1 into an empty FIFO
    idle(5, 1'b1);
    step(1'b1, 32'h3FC00000, 32'h40000000, 4'd3, 1'b1, 1'b0);
    chk("t1_issue", 64'(last_iss), 64'h1);
    for (int k = 1; k <= LAT; k++) begin
      idle(1, 1'b1);
      chk("t1_no_early_valid", 64'(last_ov), 64'h0);
    end
    idle(1, 1'b1);
    chk("t1_valid_at_lat", 64'(last_ov), 64'h1);
    chk("t1_result", 64'(pop_res), 64'h40400000);
    chk("t1_tag", 64'(pop_tag), 64'd3);
    chk("t1_flags", 64'(pop_flg), 64'h0);

    // Overflow, then sticky clear coinciding with an exception push
    step(1'b1, 32'h7F000000, 32'h7F000000, 4'd5, 1'b1, 1'b0);
    idle(LAT + 1, 1'b1);
    chk("ovf_result", 64'(pop_res), 64'h7F800000);
    chk("ovf_flags", 64'(pop_flg), 64'h2);
    idle(1, 1'b1);
    chk("ovf_sticky", 64'(sticky_flags), 64'h2);
    step(1'b1, 32'h7F800000, 32'h3F800000, 4'd6, 1'b1, 1'b0);
    idle(LAT - 1, 1'b1);
    sticky_acc = '0;
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1);   // clear in the push cycle
    idle(1, 1'b1);
    chk("clr_pop", 64'(last_pop), 64'h1);
    chk("clr_result", 64'(pop_res), 64'h0);
    chk("clr_flags", 64'(pop_flg), 64'h4);
    chk("clr_sticky", 64'(sticky_flags), 64'h4);
    chk("clr_sticky_model", 64'(sticky_flags), 64'(sticky_acc));

    // Reset mid-flight: reset lands on the first op's capture cycle
    for (int k = 0; k < 3; k++) begin
      new_op();
      step(1'b1, cur_a, cur_b, cur_t, 1'b1, 1'b0);
    end
    idle(1, 1'b1);
    reset = 1'b1;
    idle(1, 1'b1);
    reset = 1'b0;
    exp_q.delete();
    sticky_acc = '0;
    chk("mrst_in_ready", 64'(bus.in_ready), 64'h1);
    for (int k = 0; k < 10; k++) begin
      idle(1, 1'b1);
      chk("mrst_no_out_valid", 64'(last_ov), 64'h0);
    end
    chk("mrst_occupancy", 64'(occupancy), 64'h0);
    chk("mrst_sticky", 64'(sticky_flags), 64'h0);

    // Backpressure: in_valid held 12 cycles with tags 0..11, out_ready low
    nt = 0;
    new_op();
    for (int k = 0; k < 12; k++) begin
      step(1'b1, cur_a, cur_b, 4'(nt), 1'b0, 1'b0);
      if (last_iss) begin nt++; new_op(); end
    end
    chk("bp_accepted", 64'(nt), 64'd8);
    chk("bp_in_ready_low", 64'(last_ir), 64'h0);
    for (int k = 0; k < 2; k++) step(1'b1, cur_a, cur_b, 4'(nt), 1'b0, 1'b0);
    chk("bp_occupancy_full", 64'(occupancy), 64'd8);
    chk("bp_still_blocked", 64'(nt), 64'd8);
    seen_pop = 1'b0; check_ir = 1'b0; budget = 80;
    while ((nt < 12 || exp_q.size() != 0) && budget > 0) begin
      step(nt < 12, cur_a, cur_b, 4'(nt), 1'b1, 1'b0);
      budget--;
      if (check_ir) begin
        chk("bp_in_ready_after_pop", 64'(last_ir), 64'h1);
        check_ir = 1'b0;
      end
      if (last_pop && !seen_pop) begin
        seen_pop = 1'b1;
        check_ir = 1'b1;
        chk("bp_first_pop_tag", 64'(pop_tag), 64'd0);
        chk("bp_in_ready_at_pop", 64'(last_ir), 64'h0);
      end
      if (last_iss) begin nt++; new_op(); end
    end
    chk("bp_all_issued", 64'(nt), 64'd12);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Full FIFO with continuous issue and pop
    nt = 0; budget = 40;
    new_op();
    while (occupancy != 4'd8 && budget > 0) begin
      step(1'b1, cur_a, cur_b, cur_t, 1'b0, 1'b0);
      budget--;
      if (last_iss) begin nt++; new_op(); end
    end
    chk("full_fill_issued", 64'(nt), 64'd8);
    chk("full_fill_occ", 64'(occupancy), 64'd8);
    pops = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b1, cur_a, cur_b, cur_t, 1'b1, 1'b0);
      if (last_pop) pops++;
      if (last_iss) new_op();
    end
    chk("full_sustained_pops", 64'(pops), 64'd30);
    budget = 40;
    while (exp_q.size() != 0 && budget > 0) begin
      idle(1, 1'b1);
      budget--;
    end
    chk("full_drained", 64'(exp_q.size()), 64'd0);
    chk("full_occ_empty", 64'(occupancy), 64'h0);
    chk("full_sticky_model", 64'(sticky_flags), 64'(sticky_acc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
